// File: rtl/match_ctrl.sv
// Match phases, BCD scoring, win rule, serve rotation, sound arbitration and status LED for table tennis.
// Phase changes on tick-qualified clk edges, sound one clk after its cause; no backpressure, events are fire-and-forget.
module match_ctrl #(
  parameter int          WIN_SCORE       = 21,
  parameter int          WIN_MARGIN      = 2,
  parameter int          SERVE_MODE      = 1,
  parameter int          SERVES_PER_TURN = 5,
  parameter logic [11:0] SERVE_PAUSE     = 12'd1024,
  parameter logic [11:0] END_PAUSE       = 12'd4095,
  parameter logic [8:0]  LED_DIV         = 9'd256
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       gamereset,
  input  logic       outA,
  input  logic       outB,
  input  logic       collide,
  input  logic       wallbounce,
  output logic [7:0] scoreA,
  output logic [7:0] scoreB,
  output logic       service_side,
  output logic       ball_reset,
  output logic       game_over,
  output logic       winner,
  output logic       deuce,
  output logic       sfx_start,
  output logic [1:0] sfx,
  output logic [3:0] sdur,
  output logic       led
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_SERVE, S_SERVE_WAIT, S_PLAY, S_END_HOLD, S_ENDGAME
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  score_a_q, score_a_d, score_b_q, score_b_d;
  logic        serve_q, serve_d;
  logic [3:0]  turn_q, turn_d;
  logic [11:0] pause_q, pause_d;
  logic [8:0]  div_q, div_d;
  logic        led_q, led_d;
  logic        winner_q, winner_d;
  logic        sfx_start_q, sfx_start_d;
  logic [1:0]  sfx_q, sfx_d;
  logic [3:0]  sdur_q, sdur_d;
  logic        win_entry;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v == 8'h99)        return v;
    if (v[3:0] == 4'd9)    return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic int bcd_val(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  logic [7:0] inc_a, inc_b;
  int         a_val, b_val, a_inc_val, b_inc_val;
  logic       a_wins, b_wins;

  assign inc_a     = bcd_inc(score_a_q);
  assign inc_b     = bcd_inc(score_b_q);
  assign a_val     = bcd_val(score_a_q);
  assign b_val     = bcd_val(score_b_q);
  assign a_inc_val = bcd_val(inc_a);
  assign b_inc_val = bcd_val(inc_b);
  // Win is judged on the scorer's post-increment value against the opponent's unchanged score.
  assign a_wins    = (a_inc_val >= WIN_SCORE) && (a_inc_val - b_val >= WIN_MARGIN);
  assign b_wins    = (b_inc_val >= WIN_SCORE) && (b_inc_val - a_val >= WIN_MARGIN);
  assign deuce     = (WIN_MARGIN > 1) && (a_val >= WIN_SCORE - 1) && (b_val >= WIN_SCORE - 1);

  always_comb begin
    state_d     = state_q;
    score_a_d   = score_a_q;
    score_b_d   = score_b_q;
    serve_d     = serve_q;
    turn_d      = turn_q;
    pause_d     = pause_q;
    div_d       = div_q;
    led_d       = led_q;
    winner_d    = winner_q;
    sfx_start_d = 1'b0;
    sfx_d       = sfx_q;
    sdur_d      = sdur_q;
    win_entry   = 1'b0;

    if (state_q != S_IDLE && state_q != S_ENDGAME) led_d = 1'b1;

    if (gamereset) begin
      state_d   = S_INIT;
      pause_d   = 12'd0;
      score_a_d = 8'h00;
      score_b_d = 8'h00;
      serve_d   = 1'b0;
      turn_d    = 4'd0;
      led_d     = 1'b1;
    end else if (tick) begin
      case (state_q)
        S_IDLE, S_ENDGAME: begin
          if (div_q == LED_DIV - 9'd1) begin
            div_d = 9'd0;
            led_d = ~led_q;
          end else begin
            div_d = div_q + 9'd1;
          end
        end
        S_INIT: begin
          score_a_d = 8'h00;
          score_b_d = 8'h00;
          serve_d   = 1'b0;
          turn_d    = 4'd0;
          led_d     = 1'b1;
          state_d   = S_SERVE;
        end
        S_SERVE: begin
          pause_d = SERVE_PAUSE;
          state_d = S_SERVE_WAIT;
        end
        S_SERVE_WAIT: begin
          if (pause_q == 12'd0) state_d = S_PLAY;
          else                  pause_d = pause_q - 12'd1;
        end
        S_PLAY: begin
          if (outA ^ outB) begin
            if (outB) score_a_d = inc_a;
            else      score_b_d = inc_b;
            if (deuce) begin
              serve_d = ~serve_q;
              turn_d  = 4'd0;
            end else if (SERVE_MODE == 0) begin
              serve_d = outB;
            end else if (turn_q == 4'(SERVES_PER_TURN - 1)) begin
              turn_d  = 4'd0;
              serve_d = ~serve_q;
            end else begin
              turn_d  = turn_q + 4'd1;
            end
            if ((outB && a_wins) || (outA && b_wins)) begin
              state_d   = S_END_HOLD;
              pause_d   = END_PAUSE;
              winner_d  = outA;
              win_entry = 1'b1;
            end else begin
              state_d = S_SERVE;
            end
          end else if (outA && outB) begin
            state_d = S_SERVE;
          end
        end
        S_END_HOLD: begin
          if (pause_q == 12'd0) begin
            state_d = S_ENDGAME;
            div_d   = 9'd0;
          end else begin
            pause_d = pause_q - 12'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (collide || wallbounce || outA || outB) begin
      sfx_start_d = 1'b1;
      sfx_d       = collide ? 2'd0 : (wallbounce ? 2'd1 : 2'd2);
      sdur_d      = (collide || wallbounce) ? 4'd0 : 4'd1;
    end
    if (win_entry) begin
      sfx_start_d = 1'b1;
      sfx_d       = 2'd3;
      sdur_d      = 4'hF;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      score_a_q   <= 8'h00;
      score_b_q   <= 8'h00;
      serve_q     <= 1'b0;
      turn_q      <= 4'd0;
      pause_q     <= 12'd0;
      div_q       <= 9'd0;
      led_q       <= 1'b0;
      winner_q    <= 1'b0;
      sfx_start_q <= 1'b0;
      sfx_q       <= 2'd0;
      sdur_q      <= 4'd0;
    end else begin
      state_q     <= state_d;
      score_a_q   <= score_a_d;
      score_b_q   <= score_b_d;
      serve_q     <= serve_d;
      turn_q      <= turn_d;
      pause_q     <= pause_d;
      div_q       <= div_d;
      led_q       <= led_d;
      winner_q    <= winner_d;
      sfx_start_q <= sfx_start_d;
      sfx_q       <= sfx_d;
      sdur_q      <= sdur_d;
    end
  end

  // The ball is released as soon as the serve pause has run out, one tick ahead of PLAY.
  assign ball_reset   = !((state_q == S_PLAY) || (state_q == S_SERVE_WAIT && pause_q == 12'd0));
  assign game_over    = (state_q == S_END_HOLD) || (state_q == S_ENDGAME);
  assign scoreA       = score_a_q;
  assign scoreB       = score_b_q;
  assign service_side = serve_q;
  assign winner       = winner_q;
  assign sfx_start    = sfx_start_q;
  assign sfx          = sfx_q;
  assign sdur         = sdur_q;
  assign led          = led_q;

endmodule

// File: tb/tb_match_ctrl.sv
// Random-stimulus bench for match_ctrl: two instances (alternating and loser-serves) share stimulus
// and are compared against a point-level score/serve model plus a per-clk sound model.
module tb_match_ctrl;
  localparam int WS = 21, WM = 2, SPT = 5, SP = 30, EP = 60, LD = 16;

  logic clk = 1'b0, reset_n = 1'b0, tick = 1'b0, gamereset = 1'b0;
  logic outA = 1'b0, outB = 1'b0, collide = 1'b0, wallbounce = 1'b0;
  logic [7:0] d1_score_a, d1_score_b, d0_score_a, d0_score_b;
  logic d1_service, d1_ball_reset, d1_game_over, d1_winner, d1_deuce, d1_sfx_start, d1_led;
  logic d0_service, d0_ball_reset, d0_game_over, d0_winner, d0_deuce, d0_sfx_start, d0_led;
  logic [1:0] d1_sfx, d0_sfx;
  logic [3:0] d1_sdur, d0_sdur;

  int checks = 0, errors = 0;
  int ma, mb, sv1, sv0, turn1, gover, mwin;
  int e_start = 0, e_sfx = 0, e_sdur = 0;

  match_ctrl #(.WIN_SCORE(WS), .WIN_MARGIN(WM), .SERVE_MODE(1), .SERVES_PER_TURN(SPT),
               .SERVE_PAUSE(12'(SP)), .END_PAUSE(12'(EP)), .LED_DIV(9'(LD))) u_dut (
    .clk(clk), .reset_n(reset_n), .tick(tick), .gamereset(gamereset), .outA(outA), .outB(outB),
    .collide(collide), .wallbounce(wallbounce), .scoreA(d1_score_a), .scoreB(d1_score_b),
    .service_side(d1_service), .ball_reset(d1_ball_reset), .game_over(d1_game_over),
    .winner(d1_winner), .deuce(d1_deuce), .sfx_start(d1_sfx_start), .sfx(d1_sfx),
    .sdur(d1_sdur), .led(d1_led));

  match_ctrl #(.WIN_SCORE(WS), .WIN_MARGIN(WM), .SERVE_MODE(0), .SERVES_PER_TURN(SPT),
               .SERVE_PAUSE(12'(SP)), .END_PAUSE(12'(EP)), .LED_DIV(9'(LD))) u_dut0 (
    .clk(clk), .reset_n(reset_n), .tick(tick), .gamereset(gamereset), .outA(outA), .outB(outB),
    .collide(collide), .wallbounce(wallbounce), .scoreA(d0_score_a), .scoreB(d0_score_b),
    .service_side(d0_service), .ball_reset(d0_ball_reset), .game_over(d0_game_over),
    .winner(d0_winner), .deuce(d0_deuce), .sfx_start(d0_sfx_start), .sfx(d0_sfx),
    .sdur(d0_sdur), .led(d0_led));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    int s;
    s = (v > 99) ? 99 : v;
    return 8'(((s / 10) << 4) | (s % 10));
  endfunction

  function automatic logic rt();
    return ($urandom_range(0, 3) != 0);
  endfunction

  function automatic int m_deuce();
    return ((WM > 1) && ma >= WS - 1 && mb >= WS - 1) ? 1 : 0;
  endfunction

  // One clk; the sound outputs are predicted from the inputs presented to that edge.
  task automatic step(input bit win_now);
    bit trig, c, w;
    c = collide; w = wallbounce;
    trig = collide | wallbounce | outA | outB;
    @(posedge clk); #1;
    if (!reset_n) begin e_start = 0; e_sfx = 0; e_sdur = 0; end
    else if (win_now) begin e_start = 1; e_sfx = 3; e_sdur = 15; end
    else if (trig) begin
      e_start = 1;
      e_sfx   = c ? 0 : (w ? 1 : 2);
      e_sdur  = (e_sfx == 2) ? 1 : 0;
    end else e_start = 0;
    chk("sfx_start", d1_sfx_start, e_start);
    chk("sfx", d1_sfx, e_sfx);
    chk("sdur", d1_sdur, e_sdur);
    chk("m0_sfx_start", d0_sfx_start, e_start);
    chk("m0_sfx", d0_sfx, e_sfx);
    chk("m0_sdur", d0_sdur, e_sdur);
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_scoreA"}, d1_score_a, to_bcd(ma));
    chk({tag, "_scoreB"}, d1_score_b, to_bcd(mb));
    chk({tag, "_m0_scoreA"}, d0_score_a, to_bcd(ma));
    chk({tag, "_m0_scoreB"}, d0_score_b, to_bcd(mb));
    chk({tag, "_service"}, d1_service, sv1);
    chk({tag, "_m0_service"}, d0_service, sv0);
    chk({tag, "_deuce"}, d1_deuce, m_deuce());
    chk({tag, "_m0_deuce"}, d0_deuce, m_deuce());
    chk({tag, "_game_over"}, d1_game_over, gover);
    chk({tag, "_m0_game_over"}, d0_game_over, gover);
    chk({tag, "_led"}, d1_led, 1);
    chk({tag, "_m0_led"}, d0_led, 1);
    if (gover != 0) begin
      chk({tag, "_winner"}, d1_winner, mwin);
      chk({tag, "_m0_winner"}, d0_winner, mwin);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_scoreA"}, d1_score_a, 0);
    chk({tag, "_scoreB"}, d1_score_b, 0);
    chk({tag, "_service"}, d1_service, 0);
    chk({tag, "_ball_reset"}, d1_ball_reset, 1);
    chk({tag, "_m0_ball_reset"}, d0_ball_reset, 1);
    chk({tag, "_game_over"}, d1_game_over, 0);
    chk({tag, "_winner"}, d1_winner, 0);
    chk({tag, "_deuce"}, d1_deuce, 0);
    chk({tag, "_led"}, d1_led, 0);
    chk({tag, "_m0_led"}, d0_led, 0);
  endtask

  task automatic new_game();
    ma = 0; mb = 0; sv1 = 0; sv0 = 0; turn1 = 0; gover = 0;
  endtask

  task automatic press_start();
    gamereset = 1'b1; tick = rt();
    step(0);
    gamereset = 1'b0; tick = 1'b0;
    new_game();
    check_state("init");
    chk("init_ball_reset", d1_ball_reset, 1);
  endtask

  // Counts ticks until the ball is released, with stray events sprinkled in that must not score.
  task automatic wait_play(input int exp_n);
    int n, cyc;
    n = 0; cyc = 0;
    while (d1_ball_reset === 1'b1 && cyc < 40 * exp_n) begin
      tick = rt();
      outA = ($urandom_range(0, 15) == 0);
      outB = ($urandom_range(0, 15) == 0);
      collide = ($urandom_range(0, 15) == 0);
      wallbounce = ($urandom_range(0, 15) == 0);
      step(0);
      if (tick) n++;
      cyc++;
    end
    tick = 0; outA = 0; outB = 0; collide = 0; wallbounce = 0;
    chk("release_ticks", n, exp_n);
    chk("release_ball_reset", d1_ball_reset, 0);
    chk("release_m0_ball_reset", d0_ball_reset, 0);
    check_state("serve");
  endtask

  // kind: 0 = A scores (outB), 1 = B scores (outA), 2 = both out at once.
  task automatic play_point(input int kind, input bit skip_wait, output bit won);
    int k, sc, ot, d;
    k = $urandom_range(1, 4);
    for (int i = 0; i < k; i++) begin
      tick = (i == 0) ? 1'b1 : rt();
      collide = ($urandom_range(0, 2) == 0);
      wallbounce = ($urandom_range(0, 2) == 0);
      step(0);
      chk("rally_ball_reset", d1_ball_reset, 0);
    end
    collide = 0; wallbounce = 0;
    won = 0;
    if (kind < 2) begin
      d = m_deuce();
      if (kind == 0) begin ma++; sc = ma; ot = mb; end
      else begin mb++; sc = mb; ot = ma; end
      won = (sc >= WS) && (sc - ot >= WM);
      if (d != 0) begin
        sv1 ^= 1; sv0 ^= 1; turn1 = 0;
      end else begin
        turn1++;
        if (turn1 == SPT) begin turn1 = 0; sv1 ^= 1; end
        sv0 = (kind == 0) ? 1 : 0;
      end
      if (won) begin gover = 1; mwin = kind; end
    end
    tick = 1; outA = (kind != 0); outB = (kind != 1);
    step(won);
    tick = 0; outA = 0; outB = 0;
    check_state("point");
    chk("point_ball_reset", d1_ball_reset, 1);
    if (!won && !skip_wait) wait_play(SP + 1);
  endtask

  // After the winning point: END_HOLD for EP+1 ticks, then the LED blinks every LD ticks.
  task automatic end_seq();
    int k, n, cyc, exp;
    k = 0; cyc = 0;
    while (k < EP + 1 + 2 * LD + 1 && cyc < 2000) begin
      tick = rt();
      step(0);
      if (tick) k++;
      cyc++;
      n = k - (EP + 1);
      exp = (n < 0) ? 1 : (((n / LD) % 2 == 0) ? 1 : 0);
      chk("end_led", d1_led, exp);
      chk("end_game_over", d1_game_over, 1);
    end
    tick = 0;
    chk("end_ticks", k, EP + 1 + 2 * LD + 1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, cyc, pts, kind;
    bit won;

    reset_n = 0; collide = 1; tick = rt();
    step(0); step(0);
    check_reset("reset");
    reset_n = 1; collide = 0;

    k = 0; cyc = 0;
    while (k < 2 * LD + 2 && cyc < 1000) begin
      tick = rt();
      outA = ($urandom_range(0, 7) == 0);
      step(0);
      if (tick) k++;
      cyc++;
      chk("idle_led", d1_led, (k / LD) % 2);
      chk("idle_scoreB", d1_score_b, 0);
      chk("idle_ball_reset", d1_ball_reset, 1);
    end
    tick = 0; outA = 0;

    // Game 1: steer to WS-1 all, then A takes two straight points.
    press_start();
    wait_play(SP + 2);
    collide = 1; wallbounce = 1; step(0);
    collide = 0; wallbounce = 0; step(0);
    pts = 0;
    while (!(ma == WS - 1 && mb == WS - 1) && pts < 300) begin
      if (ma == WS - 1)                     kind = 1;
      else if (mb == WS - 1)                kind = 0;
      else if ($urandom_range(0, 7) == 0)   kind = 2;
      else                                  kind = $urandom_range(0, 1);
      play_point(kind, 1'b0, won);
      pts++;
    end
    chk("deuce_at_tie", d1_deuce, 1);
    play_point(0, 1'b0, won);
    chk("advantage_no_win", won, 0);
    play_point(0, 1'b0, won);
    chk("deuce_win", won, 1);
    chk("deuce_winner", d1_winner, 0);
    end_seq();

    // Game 2: random rally outcomes, with a restart in the middle of a serve pause.
    press_start();
    wait_play(SP + 2);
    pts = 0; won = 0;
    while (!won && pts < 200) begin
      kind = ($urandom_range(0, 8) == 0) ? 2 : $urandom_range(0, 1);
      play_point(kind, pts == 3, won);
      pts++;
      if (pts == 4 && !won) begin
        tick = 1;
        repeat (SP / 2 + 2) step(0);
        chk("midpause_ball_reset", d1_ball_reset, 1);
        press_start();
        wait_play(SP + 2);
      end
    end
    chk("game2_won", won, 1);
    end_seq();

    // Reset asserted while the ball is in play.
    press_start();
    wait_play(SP + 2);
    play_point(1, 1'b0, won);
    tick = 1; step(0); tick = 0;
    chk("inplay_ball_reset", d1_ball_reset, 0);
    reset_n = 0; step(0);
    check_reset("rst_play");
    reset_n = 1; step(0);
    check_reset("rst_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/match_ctrl.md
Name: match_ctrl

Overview:
- Parametrised successor to the single-game logic FSM for the table-tennis design.
- Owns match phases (power-on idle, init, serve pause, rally, endgame), score keeping and the win rule.
- Also owns serve rotation, sound-event arbitration and the status LED.
- Sits between ballmover/collider (event inputs) and the score renderer and soundnik (outputs). The score renderer no longer counts points itself.

Parameters:
WIN_SCORE, 21, points needed to win (1..99)
WIN_MARGIN, 2, minimum lead required to win (1 = classic first-to-WIN_SCORE)
SERVE_MODE, 1, 0 = side that conceded serves next; 1 = serve alternates every SERVES_PER_TURN points
SERVES_PER_TURN, 5, points per serve turn in mode 1 (1..15)
SERVE_PAUSE, 1024, ticks spent in SERVE_WAIT (12-bit)
END_PAUSE, 4095, ticks spent in END_HOLD before ENDGAME (12-bit)
LED_DIV, 256, ticks per LED toggle while blinking (9-bit)

Ports:
clk  in  1  master clock
reset_n  in  1  synchronous, active-low reset
tick  in  1  ball-advance enable, one clk wide; FSM advances only when tick=1
gamereset  in  1  start-button pulse, sampled every clk
outA  in  1  ball left field on side A (point to B)
outB  in  1  ball left field on side B (point to A)
collide  in  1  paddle hit
wallbounce  in  1  wall hit
scoreA  out  8  BCD score for A
scoreB  out  8  BCD score for B
service_side  out  1  0 = serve from A (left), 1 = from B
ball_reset  out  1  holds ballmover at serve position
game_over  out  1  high in END_HOLD and ENDGAME
winner  out  1  0 = A won, 1 = B won; valid while game_over
deuce  out  1  both scores >= WIN_SCORE-1 and WIN_MARGIN>1
sfx_start  out  1  one-clk sound trigger
sfx  out  2  0 paddle, 1 wall, 2 point, 3 match won
sdur  out  4  sound duration code
led  out  1  status LED

Behaviour:
- Reset (reset_n=0 at posedge clk) sets:
  - state=IDLE, scores=8'h00, service_side=0, ball_reset=1.
  - game_over=0, winner=0, sfx_start=0, sfx=0, sdur=0, led=0.
  - Pause counter=0, LED divider=0, serve-turn counter=0.
- Priority at each clk: reset_n=0, then gamereset, then tick-qualified FSM.
- gamereset=1 forces state=INIT on the next clk from any state, including mid-rally and mid-pause. Pause counter is cleared.
- States (transitions taken only on clk with tick=1):
  - IDLE: ball_reset=1; LED blinks. Stays in IDLE until gamereset.
  - INIT: scores cleared to 0, service_side=0, turn counter=0, game_over=0, led=1. Next: SERVE.
  - SERVE: ball_reset=1, pause loaded with SERVE_PAUSE. Next: SERVE_WAIT.
  - SERVE_WAIT: pause decrements each tick. When the tick sees pause==0: ball_reset=0, next state PLAY. Dwell is SERVE_PAUSE+1 ticks.
  - PLAY: ball_reset=0. On tick with exactly one of outA/outB: award the point (outA: B+1; outB: A+1), update serve, evaluate the win rule. If won: go to END_HOLD with pause=END_PAUSE and ball_reset=1. Otherwise go to SERVE.
  - END_HOLD: counts down as in SERVE_WAIT, then goes to ENDGAME.
  - ENDGAME: terminal; LED blinks. Left only by gamereset or reset.
- Score arithmetic:
  - Two-digit BCD increment; low nibble 9 carries into the high nibble.
  - Saturates at 8'h99.
  - The win test uses the post-increment value.
  - Win condition: scorer >= WIN_SCORE and scorer - other >= WIN_MARGIN. winner = scoring side.
- Simultaneous outA & outB on one tick: no point awarded, serve unchanged, next state SERVE.
- outA/outB/collide/wallbounce sampled outside PLAY: no score effect.
- Serve rule:
  - Mode 0: service_side = 1 if outB scored the point, else 0.
  - Mode 1: turn counter increments per awarded point. When it reaches SERVES_PER_TURN it clears and service_side toggles.
  - While deuce=1, service_side toggles on every point (turn counter held at 0).
- Sound, evaluated every clk, independent of tick:
  - Trigger condition: (collide|wallbounce|outA|outB) & reset_n.
  - On trigger, sfx_start=1 for one clk. Priority collide > wallbounce > out.
  - sfx 0/1 with sdur=0; sfx 2 with sdur=1.
  - Entry into END_HOLD overrides the same cycle with sfx=3, sdur=4'hF.
  - sfx/sdur hold their last value between triggers.
- LED:
  - In IDLE and ENDGAME, the divider counts ticks and led toggles each LED_DIV ticks.
  - Divider is cleared on entry to each of those states.
  - Otherwise led=1 (led=0 only from reset until the first blink toggle in IDLE).

Test Plan:
- Reset then 2 ticks idle -> state IDLE, ball_reset=1, scores 00/00. gamereset pulse -> INIT; exactly 1026 ticks later ball_reset falls.
- In PLAY, 9 outB pulses on separate ticks -> scoreA=8'h09. 10th -> 8'h10; each point re-enters SERVE with ball_reset=1.
- WIN_MARGIN=2, drive to 20/20 -> deuce=1. A to 21 -> no win, serve toggles. A to 22 -> game_over=1, winner=0, sfx=3 with sfx_start pulse, END_HOLD then ENDGAME with LED blinking every 256 ticks.
- SERVE_MODE=1, SERVES_PER_TURN=5 -> service_side stays 0 for points 1-4 and flips to 1 on point 5. SERVE_MODE=0: outA point -> service_side=0.
- outA and outB on the same tick -> scores unchanged, state SERVE. collide and wallbounce on the same clk -> single sfx_start, sfx=0.
- gamereset during SERVE_WAIT (pause=500), then reset_n=0 during PLAY -> INIT with scores 00; then IDLE with all outputs at reset values.
